// File: rtl/wb_write_arbiter.sv
`default_nettype none
// ============================================================================
// wb_write_arbiter: shares the single RF write port between writeback and an
// in-order queue of long-latency results. WB_ARB_PENDING_EN adds pending_mask.
// Revision: 1.0
// ============================================================================
module wb_write_arbiter #(
  parameter int LQ_DEPTH   = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pipe_we,
  input  logic [4:0]                  pipe_rd,
  input  logic [31:0]                 pipe_data,
  output logic                        pipe_stall,
  input  logic                        lu_valid,
  output logic                        lu_ready,
  input  logic [4:0]                  lu_rd,
  input  logic [31:0]                 lu_data,
  output logic                        rf_we,
  output logic [4:0]                  rf_waddr,
  output logic [31:0]                 rf_wdata,
  output logic [$clog2(LQ_DEPTH):0]   q_count
`ifdef WB_ARB_PENDING_EN
  ,
  output logic [31:0]                 pending_mask
`endif
);

  localparam int PW = $clog2(LQ_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(LQ_DEPTH);
  localparam logic [SW-1:0] SMAX_C  = SW'(STARVE_MAX);

  logic [4:0]    q_rd_q   [LQ_DEPTH];
  logic [4:0]    q_rd_d   [LQ_DEPTH];
  logic [31:0]   q_data_q [LQ_DEPTH];
  logic [31:0]   q_data_d [LQ_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          rf_we_q, rf_we_d;
  logic [4:0]    rf_waddr_q, rf_waddr_d;
  logic [31:0]   rf_wdata_q, rf_wdata_d;

  logic pipe_wr, force_drain, grant_queue, grant_pipe, enq;

  // Arbitration decisions depend on registered queue state only, so the
  // stall and ready outputs have no combinational path from the inputs.
  always_comb begin
    pipe_wr     = pipe_we && (pipe_rd != 5'd0);
    force_drain = (count_q != '0) && ((count_q == DEPTH_C) || (starve_q == SMAX_C));
    grant_queue = force_drain || (!pipe_wr && (count_q != '0));
    grant_pipe  = !force_drain && pipe_wr;
    lu_ready    = (count_q < DEPTH_C);
    enq         = lu_valid && lu_ready && (lu_rd != 5'd0);
    pipe_stall  = force_drain;
  end

  always_comb begin
    q_rd_d     = q_rd_q;
    q_data_d   = q_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    starve_d   = starve_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;

    if (enq) begin
      q_rd_d[wr_ptr_q]   = lu_rd;
      q_data_d[wr_ptr_q] = lu_data;
      wr_ptr_d           = wr_ptr_q + PW'(1);
    end

    if (grant_queue) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = q_rd_q[rd_ptr_q];
      rf_wdata_d = q_data_q[rd_ptr_q];
      rd_ptr_d   = rd_ptr_q + PW'(1);
    end else if (grant_pipe) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = pipe_rd;
      rf_wdata_d = pipe_data;
    end

    case ({enq, grant_queue})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if ((count_q == '0) || grant_queue) begin
      starve_d = '0;
    end else if (starve_q != SMAX_C) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LQ_DEPTH; i++) begin
        q_rd_q[i]   <= 5'd0;
        q_data_q[i] <= 32'd0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= 32'd0;
    end else begin
      q_rd_q     <= q_rd_d;
      q_data_q   <= q_data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign q_count  = count_q;

`ifdef WB_ARB_PENDING_EN
  // Live queue entries are the count_q slots starting at the read pointer.
  always_comb begin
    pending_mask = 32'd0;
    for (int k = 0; k < LQ_DEPTH; k++) begin
      if (CW'(k) < count_q) begin
        pending_mask[q_rd_q[rd_ptr_q + PW'(k)]] = 1'b1;
      end
    end
    if (rf_we_q) begin
      pending_mask[rf_waddr_q] = 1'b1;
    end
    pending_mask[0] = 1'b0;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_write_arbiter.sv
`default_nettype none
// ============================================================================
// tb_wb_write_arbiter: queue-level reference model compared every cycle, plus
// hand-computed directed checks. Revision: 1.0
// ============================================================================
module tb_wb_write_arbiter;

  localparam int LQ_DEPTH   = 2;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        pipe_stall;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0]  q_count;
`ifdef WB_ARB_PENDING_EN
  logic [31:0] pending_mask;
`endif

  always #5 clk = ~clk;

  wb_write_arbiter #(.LQ_DEPTH(LQ_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data), .pipe_stall(pipe_stall),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .q_count(q_count)
`ifdef WB_ARB_PENDING_EN
    , .pending_mask(pending_mask)
`endif
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  // Reference model: the queue as a list, the starve count as an integer.
  ent_t        mq[$];
  int          m_starve;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  ent_t wlog[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_force();
    return (mq.size() != 0) && ((mq.size() == LQ_DEPTH) || (m_starve == STARVE_MAX));
  endfunction

  task automatic model_reset();
    mq.delete();
    m_starve = 0;
    m_we     = 1'b0;
    m_addr   = 5'd0;
    m_data   = 32'd0;
  endtask

  task automatic model_step(input logic we, input logic [4:0] rd, input logic [31:0] d,
                            input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                            input logic r);
    logic gq, gp, acc;
    int   sz;
    ent_t head;
    if (r) begin
      model_reset();
    end else begin
      sz  = mq.size();
      gq  = m_force() || (!(we && rd != 0) && sz != 0);
      gp  = !gq && we && rd != 0;
      acc = lv && (sz < LQ_DEPTH) && (lrd != 0);
      m_we = gq || gp;
      if (gq) begin
        head   = mq.pop_front();
        m_addr = head.rd;
        m_data = head.d;
      end else if (gp) begin
        m_addr = rd;
        m_data = d;
      end
      if (sz == 0 || gq) m_starve = 0;
      else if (m_starve < STARVE_MAX) m_starve++;
      if (acc) mq.push_back({lrd, ld});
    end
  endtask

  // Per-cycle comparison of every output against the model's current state.
  task automatic check_cycle();
    chk("pipe_stall", {31'd0, pipe_stall}, {31'd0, m_force()});
    chk("lu_ready", {31'd0, lu_ready}, {31'd0, mq.size() < LQ_DEPTH});
    chk("q_count", {30'd0, q_count}, mq.size());
    chk("rf_we", {31'd0, rf_we}, {31'd0, m_we});
    chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, m_addr});
    chk("rf_wdata", rf_wdata, m_data);
`ifdef WB_ARB_PENDING_EN
    begin
      logic [31:0] em;
      em = 32'd0;
      foreach (mq[i]) em[mq[i].rd] = 1'b1;
      if (m_we) em[m_addr] = 1'b1;
      em[0] = 1'b0;
      chk("pending_mask", pending_mask, em);
    end
`endif
    if (rf_we) wlog.push_back({rf_waddr, rf_wdata});
  endtask

  task automatic cycle(input logic we, input logic [4:0] rd, input logic [31:0] d,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                       input logic r);
    @(negedge clk);
    check_cycle();
    pipe_we = we; pipe_rd = rd; pipe_data = d;
    lu_valid = lv; lu_rd = lrd; lu_data = ld;
    rst = r;
    model_step(we, rd, d, lv, lrd, ld, r);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  initial begin
    int   accepted;
    int   guard;
    int   hits;
    logic [31:0] d;

    rst = 1'b1; pipe_we = 1'b0; pipe_rd = 5'd0; pipe_data = 32'd0;
    lu_valid = 1'b0; lu_rd = 5'd0; lu_data = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("reset q_count", {30'd0, q_count}, 32'd0);
    chk("reset lu_ready", {31'd0, lu_ready}, 32'd1);
    chk("reset rf_we", {31'd0, rf_we}, 32'd0);
    chk("reset pipe_stall", {31'd0, pipe_stall}, 32'd0);

    // Plain pipeline write.
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0);
    #1;
    chk("pipe wr rf_we", {31'd0, rf_we}, 32'd1);
    chk("pipe wr addr", {27'd0, rf_waddr}, 32'd5);
    chk("pipe wr data", rf_wdata, 32'hDEADBEEF);
    idle(1);
    #1;
    chk("pipe wr one pulse", {31'd0, rf_we}, 32'd0);

    // Long-latency result into an empty queue, idle pipeline.
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h12345678, 1'b0);
    #1;
    chk("lu accept q_count", {30'd0, q_count}, 32'd1);
    idle(1);
    #1;
    chk("lu drain rf_waddr", {27'd0, rf_waddr}, 32'd7);
    chk("lu drain q_count", {30'd0, q_count}, 32'd0);
    idle(1);

    // Starvation: one queued entry behind a busy pipeline.
    wlog.delete();
    cycle(1'b1, 5'd3, 32'd100, 1'b1, 5'd10, 32'hAAAA, 1'b0);
    accepted = 0; d = 32'd101; guard = 0;
    while (accepted < 6 && guard < 20) begin
      logic st;
      st = m_force();
      cycle(1'b1, 5'd3, d, 1'b0, 5'd0, 32'd0, 1'b0);
      if (!st) begin accepted++; d++; end
      guard++;
    end
    chk("starve loop bound", guard, 32'd7);
    idle(2);
    chk("starve write count", wlog.size(), 32'd8);
    if (wlog.size() == 8) begin
      chk("starve 4 pipe writes first", {27'd0, wlog[4].rd}, 32'd3);
      chk("starve forced entry", {27'd0, wlog[5].rd}, 32'd10);
      chk("starve held pipe write", wlog[6].d, 32'd105);
    end

    // Fill the queue while the pipeline writes.
    wlog.delete();
    cycle(1'b1, 5'd4, 32'd200, 1'b1, 5'd8, 32'h88, 1'b0);
    cycle(1'b1, 5'd4, 32'd201, 1'b1, 5'd9, 32'h99, 1'b0);
    #1;
    chk("full q_count", {30'd0, q_count}, 32'd2);
    chk("full lu_ready", {31'd0, lu_ready}, 32'd0);
    chk("full pipe_stall", {31'd0, pipe_stall}, 32'd1);
    cycle(1'b1, 5'd4, 32'd202, 1'b0, 5'd0, 32'd0, 1'b0);
    #1;
    chk("after dequeue lu_ready", {31'd0, lu_ready}, 32'd1);
    chk("first drained reg", {27'd0, rf_waddr}, 32'd8);
    cycle(1'b1, 5'd4, 32'd202, 1'b0, 5'd0, 32'd0, 1'b0);
    idle(3);
    chk("fill write count", wlog.size(), 32'd5);
    if (wlog.size() == 5) begin
      chk("order reg 8", {27'd0, wlog[2].rd}, 32'd8);
      chk("order held pipe", wlog[3].d, 32'd202);
      chk("order reg 9", {27'd0, wlog[4].rd}, 32'd9);
    end

    // rd=0 from both sources never uses the port.
    cycle(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66, 1'b0);
    #1;
    chk("rd0 rf_we", {31'd0, rf_we}, 32'd0);
    chk("rd0 q_count", {30'd0, q_count}, 32'd0);
    chk("rd0 pipe_stall", {31'd0, pipe_stall}, 32'd0);

    // Reset with a full queue flushes it.
    cycle(1'b1, 5'd6, 32'd1, 1'b1, 5'd11, 32'hB1, 1'b0);
    cycle(1'b1, 5'd6, 32'd2, 1'b1, 5'd12, 32'hB2, 1'b0);
    #1;
    chk("pre-reset q_count", {30'd0, q_count}, 32'd2);
    wlog.delete();
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    #1;
    chk("flush q_count", {30'd0, q_count}, 32'd0);
    chk("flush rf_we", {31'd0, rf_we}, 32'd0);
    chk("flush lu_ready", {31'd0, lu_ready}, 32'd1);
    chk("flush pipe_stall", {31'd0, pipe_stall}, 32'd0);
    idle(4);
    hits = 0;
    foreach (wlog[i]) if (wlog[i].rd == 5'd11 || wlog[i].rd == 5'd12) hits++;
    chk("flushed entries never written", hits, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Arbitrates the single integer register-file write port between the in-order writeback result and results from long-latency units (mul/div, CSR-side helpers).
- Long-latency results are buffered in a small in-order queue.
- Normally drained in cycles where the pipeline does not write. When the queue is full or starving, the block stalls the pipeline's writeback for one cycle.
- Sits between the writeback pipeline register and the register file.

Parameters:
- LQ_DEPTH, 2, long-latency result queue depth; power of 2, ≥2.
- STARVE_MAX, 4, consecutive denied cycles before a queue entry is forced through; ≥1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- pipe_we  in  1  pipeline writeback write enable
- pipe_rd  in  5  pipeline destination register
- pipe_data  in  32  pipeline write data
- pipe_stall  out  1  pipeline write not taken this cycle; upstream holds pipe_* and the stages behind it
- lu_valid  in  1  long-latency result offered
- lu_ready  out  1  queue can accept (valid&ready = transfer)
- lu_rd  in  5  long-latency destination register
- lu_data  in  32  long-latency result
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  5  register-file write address (registered)
- rf_wdata  out  32  register-file write data (registered)
- q_count  out  $clog2(LQ_DEPTH)+1  current queue occupancy

Behaviour:
- Reset values:
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - Queue empty: q_count=0, lu_ready=1.
  - Starve counter=0, pipe_stall=0.
- Reset mid-operation discards all queued entries. No partial write is issued after reset.
- Effective pipeline write: pipe_wr = pipe_we && pipe_rd!=0. An rd=0 write never uses the port.
- Queue: circular FIFO, wr/rd pointers wrap modulo LQ_DEPTH.
  - lu_ready = (q_count < LQ_DEPTH). It is a function of registered state only; there is no same-cycle dequeue bypass.
  - Transfer with lu_rd=0: accepted (ready honoured) and discarded, not enqueued.
- force = q_count!=0 && (q_count==LQ_DEPTH || starve==STARVE_MAX).
- Grant each cycle, exactly one source or none:
  - force=1: grant queue head; pipe_stall=1 (even if pipe_wr=0).
  - else pipe_wr=1: grant pipeline; pipe_stall=0.
  - else q_count!=0: grant queue head.
  - else no grant.
- pipe_stall is combinational from registered state only; no path from pipe_* or lu_* inputs.
- A granted write at cycle N appears on rf_we/rf_waddr/rf_wdata at cycle N+1 for exactly one cycle. rf_we=0 otherwise; rf_waddr/rf_wdata hold their last value.
- Enqueue and dequeue in the same cycle are both allowed; q_count is unchanged.
- A long-latency result accepted at N is written to rf at N+2 at the earliest (empty queue, no pipe_wr at N+1).
- Starve counter:
  - +1 (saturating at STARVE_MAX) each cycle q_count!=0 and the queue is not granted.
  - Cleared to 0 when the queue is granted or the queue is empty.
- Ordering: queue entries retire strictly in acceptance order.
- The block does not resolve same-rd WAW ordering between sources; the issue logic must prevent it.

Optional Feature:
- Macro WB_ARB_PENDING_EN.
- Defined:
  - Adds output pending_mask [31:0].
  - Bit r=1 while any valid queue entry or the registered rf output with rf_we=1 targets register r.
  - Bit 0 is always 0.
  - Cleared on reset.
  - Used by issue logic for RAW/WAW interlock.
- Undefined: port and tracking logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then pipe_we=1, pipe_rd=5, pipe_data=0xDEADBEEF for 1 cycle -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; pipe_stall=0 throughout.
- Idle pipeline; lu_valid=1, lu_rd=7, lu_data=0x12345678 at cycle 0 -> lu_ready=1, q_count=1 at cycle 1, rf write of reg 7 visible at cycle 2, q_count=0 at cycle 2.
- Queue holds 1 entry, pipe_we=1 with rd=3 every cycle (STARVE_MAX=4) -> 4 pipeline writes, then pipe_stall=1 for exactly 1 cycle. The queued entry is written; the held pipeline write follows the next cycle, with no data lost.
- Fill queue with 2 entries (rd 8, 9) while pipe_we=1 -> lu_ready=0 and pipe_stall=1 while q_count=2. Writes are reg 8 then reg 9 in order; lu_ready returns to 1 after the first dequeue.
- pipe_we=1, pipe_rd=0 and lu transfer with lu_rd=0 -> no rf_we pulse, q_count stays 0, no stall.
- Queue holding 2 entries, assert rst for 1 cycle -> q_count=0, rf_we=0, lu_ready=1, pipe_stall=0; no write of the flushed entries ever appears.
